if_window_addr_gen: RTL

- Parametrised successor to the PE ifmap address generator.
- Sequences ifmap scratchpad read addresses for a 1-D convolution row with configurable filter size, stride and interleaved input channels.
- The scratchpad is a circular buffer of DEPTH words. The block tracks its head pointer, stalls on insufficient fill and returns consumed entries to the write side.
- Sits between the PE control FSM and the ifmap spad read port, alongside the filter address generator.

---
 rtl/pe_pkg.sv | 29 ++
 rtl/circ_ptr.sv | 27 ++
 rtl/if_window_addr_gen.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/pe_pkg.sv
// Shared types and helpers for the PE address generators (ifmap, filter, psum).
// Holds the controller state encoding and the circular-buffer pointer arithmetic.
package pe_pkg;

    localparam int DEFAULT_DEPTH  = 12;
    localparam int DEFAULT_CFG_W  = 5;
    localparam int DEFAULT_MAX_CH = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CHECK,
        ST_RUN,
        ST_FINISH
    } pe_state_t;

    // (ptr + inc) mod depth for ptr < depth and inc <= depth; a single
    // compare-subtract replaces the divider.
    function automatic logic [31:0] wrap_add(input logic [31:0] ptr,
                                             input logic [31:0] inc,
                                             input logic [31:0] depth);
        logic [31:0] sum;
        sum = ptr + inc;
        if (sum >= depth) begin
            sum = sum - depth;
        end
        return sum;
    endfunction

endpackage

// File: rtl/circ_ptr.sv
// Head pointer of a circular scratchpad of DEPTH words (DEPTH need not be a power of 2).
// Advances by inc on every inc_en cycle; shared by the ifmap, filter and psum generators.
module circ_ptr
    import pe_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc_en,
    input  logic [CNT_W-1:0]  inc,
    output logic [ADDR_W-1:0] ptr
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (inc_en) begin
            ptr <= ADDR_W'(wrap_add(32'(ptr), 32'(inc), 32'(DEPTH)));
        end
    end

endmodule

// File: rtl/if_window_addr_gen.sv
// Ifmap scratchpad read-address sequencer for one 1-D convolution row with S taps,
// stride U and C interleaved channels; releases consumed words back to the writer.
module if_window_addr_gen
    import pe_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int CFG_W  = DEFAULT_CFG_W,
    parameter int MAX_CH = DEFAULT_MAX_CH,
    parameter int CH_W   = $clog2(MAX_CH + 1),
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CFG_W-1:0]  cfg_ifmap_size,
    input  logic [CFG_W-1:0]  cfg_filt_size,
    input  logic [CFG_W-1:0]  cfg_stride,
    input  logic [CH_W-1:0]   cfg_channels,
    input  logic [CNT_W-1:0]  avail_cnt,
    input  logic              rd_ready,
    output logic              rd_valid,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [CFG_W-1:0]  rd_tap,
    output logic [CH_W-1:0]   rd_chan,
    output logic              rd_last,
    output logic              release_valid,
    output logic [CNT_W-1:0]  release_cnt,
    output logic [ADDR_W-1:0] head_ptr,
    output logic              busy,
    output logic              done,
    output logic              cfg_err
);

    localparam int EXT_W = CNT_W + CFG_W;
    localparam logic [EXT_W-1:0] DEPTH_X  = EXT_W'(DEPTH);
    localparam logic [EXT_W-1:0] MAX_CH_X = EXT_W'(MAX_CH);

    pe_state_t state_q, state_d;

    logic [CFG_W-1:0] w_q, w_d, s_q, s_d, u_q, u_d;
    logic [CH_W-1:0]  chn_q, chn_d;
    logic [CFG_W-1:0] win_q, win_d, k_q, k_d;
    logic [CH_W-1:0]  ch_q, ch_d;
    logic             rel_valid_q, rel_valid_d;
    logic [CNT_W-1:0] rel_cnt_q, rel_cnt_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    // Widened copies so products and sums are never truncated before a compare.
    logic [EXT_W-1:0] w_x, s_x, u_x, c_x, win_x, k_x, ch_x;
    logic [EXT_W-1:0] off, step_cnt, tail_cnt;
    logic             cfg_bad, final_win, in_run, accept;

    assign w_x   = EXT_W'(w_q);
    assign s_x   = EXT_W'(s_q);
    assign u_x   = EXT_W'(u_q);
    assign c_x   = EXT_W'(chn_q);
    assign win_x = EXT_W'(win_q);
    assign k_x   = EXT_W'(k_q);
    assign ch_x  = EXT_W'(ch_q);

    // head_ptr already absorbs win*C from earlier releases, so the offset from
    // the head is only the in-window part; it is also what avail_cnt counts.
    assign off      = k_x * c_x + ch_x;
    assign step_cnt = u_x * c_x;
    assign tail_cnt = (w_x - win_x) * c_x;

    assign cfg_bad   = (s_x == '0) || (u_x == '0) || (c_x == '0) || (c_x > MAX_CH_X)
                    || (s_x > w_x) || (w_x * c_x > DEPTH_X);
    assign final_win = (win_x + u_x + s_x) > w_x;

    assign in_run   = (state_q == ST_RUN);
    assign rd_valid = in_run && !rel_valid_q && (off < EXT_W'(avail_cnt));
    assign rd_addr  = in_run ? ADDR_W'(wrap_add(32'(head_ptr), 32'(off), 32'(DEPTH))) : '0;
    assign rd_last  = in_run && (k_q == s_q - CFG_W'(1)) && (ch_q == chn_q - CH_W'(1));
    assign accept   = rd_valid && rd_ready;

    // NOTE: every variable driven here gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        w_d         = w_q;
        s_d         = s_q;
        u_d         = u_q;
        chn_d       = chn_q;
        win_d       = win_q;
        k_d         = k_q;
        ch_d        = ch_q;
        rel_valid_d = 1'b0;
        rel_cnt_d   = rel_cnt_q;
        done_d      = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    w_d     = cfg_ifmap_size;
                    s_d     = cfg_filt_size;
                    u_d     = cfg_stride;
                    chn_d   = cfg_channels;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (cfg_bad) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    win_d   = '0;
                    k_d     = '0;
                    ch_d    = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    if (ch_q == chn_q - CH_W'(1)) begin
                        ch_d = '0;
                        if (k_q == s_q - CFG_W'(1)) begin
                            k_d         = '0;
                            rel_valid_d = 1'b1;
                            if (final_win) begin
                                // The last release also frees the unused tail of the row.
                                rel_cnt_d = CNT_W'(tail_cnt);
                                done_d    = 1'b1;
                                state_d   = ST_FINISH;
                            end else begin
                                rel_cnt_d = CNT_W'(step_cnt);
                                win_d     = win_q + u_q;
                            end
                        end else begin
                            k_d = k_q + CFG_W'(1);
                        end
                    end else begin
                        ch_d = ch_q + CH_W'(1);
                    end
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            w_q         <= '0;
            s_q         <= '0;
            u_q         <= '0;
            chn_q       <= '0;
            win_q       <= '0;
            k_q         <= '0;
            ch_q        <= '0;
            rel_valid_q <= 1'b0;
            rel_cnt_q   <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            w_q         <= w_d;
            s_q         <= s_d;
            u_q         <= u_d;
            chn_q       <= chn_d;
            win_q       <= win_d;
            k_q         <= k_d;
            ch_q        <= ch_d;
            rel_valid_q <= rel_valid_d;
            rel_cnt_q   <= rel_cnt_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // The head moves at the end of the release cycle, so reads resume from the new head.
    circ_ptr #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_head (
        .clk    (clk),
        .rst    (rst),
        .inc_en (rel_valid_q),
        .inc    (rel_cnt_q),
        .ptr    (head_ptr)
    );

    assign rd_tap        = k_q;
    assign rd_chan       = ch_q;
    assign release_valid = rel_valid_q;
    assign release_cnt   = rel_cnt_q;
    assign busy          = (state_q != ST_IDLE);
    assign done          = done_q;
    assign cfg_err       = err_q;

endmodule
